riscv_amo_mem_responder: RTL and testbench

//  Memory-side responder for LSU atomic requests: takes one AMO*.W/.D request, reads the

---
 rtl/riscv_amo_mem_responder.sv | 159 +++++++++++++++
 tb/tb_riscv_amo_mem_responder.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/riscv_amo_mem_responder.sv
// rtl/riscv_amo_mem_responder.sv - read-modify-write responder for RISC-V AMO*.W/.D requests
module riscv_amo_mem_responder #(
    parameter int MEM_RD_LATENCY = 1
) (
    input  logic        i_riscv_lsu_clk,
    input  logic        i_riscv_lsu_rst,
    input  logic        i_riscv_amo_req_valid,
    output logic        o_riscv_amo_req_ready,
    input  logic [4:0]  i_riscv_amo_funct5,
    input  logic        i_riscv_amo_word,
    input  logic [63:0] i_riscv_amo_addr,
    input  logic [63:0] i_riscv_amo_src,
    input  logic        i_riscv_amo_flush,
    output logic        o_riscv_amo_rsp_valid,
    input  logic        i_riscv_amo_rsp_ready,
    output logic [63:0] o_riscv_amo_rsp_data,
    output logic        o_riscv_amo_rsp_err,
    output logic        o_riscv_mem_en,
    output logic        o_riscv_mem_we,
    output logic [63:0] o_riscv_mem_addr,
    output logic [63:0] o_riscv_mem_wdata,
    output logic [7:0]  o_riscv_mem_wstrb,
    input  logic [63:0] i_riscv_mem_rdata
);

    localparam logic [4:0] F_ADD  = 5'b00000;
    localparam logic [4:0] F_SWAP = 5'b00001;
    localparam logic [4:0] F_XOR  = 5'b00100;
    localparam logic [4:0] F_OR   = 5'b01000;
    localparam logic [4:0] F_AND  = 5'b01100;
    localparam logic [4:0] F_MIN  = 5'b10000;
    localparam logic [4:0] F_MAX  = 5'b10100;
    localparam logic [4:0] F_MINU = 5'b11000;
    localparam logic [4:0] F_MAXU = 5'b11100;

    localparam int CW = (MEM_RD_LATENCY > 1) ? $clog2(MEM_RD_LATENCY) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(MEM_RD_LATENCY - 1);

    typedef enum logic [2:0] {S_IDLE, S_READ, S_WAIT, S_WRITE, S_RESP} state_t;

    state_t        state_q, state_d;
    logic [4:0]    funct5_q, funct5_d;
    logic          word_q, word_d;
    logic [63:2]   addr_q, addr_d;
    logic [63:0]   src_q, src_d;
    logic [63:0]   old_q, old_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          err_q, err_d;

    logic          misaligned;
    logic [63:0]   src_ext;
    logic [63:0]   result;
    logic [31:0]   rd_half;

    // Request state and FSM register; reset drops any pending write immediately.
    always_ff @(posedge i_riscv_lsu_clk or posedge i_riscv_lsu_rst) begin
        if (i_riscv_lsu_rst) begin
            state_q  <= S_IDLE;
            funct5_q <= '0;
            word_q   <= 1'b0;
            addr_q   <= '0;
            src_q    <= '0;
            old_q    <= '0;
            cnt_q    <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            funct5_q <= funct5_d;
            word_q   <= word_d;
            addr_q   <= addr_d;
            src_q    <= src_d;
            old_q    <= old_d;
            cnt_q    <= cnt_d;
            err_q    <= err_d;
        end
    end

    // Next-state: accept, read, wait out memory latency, write, hold response.
    always_comb begin
        state_d    = state_q;
        funct5_d   = funct5_q;
        word_d     = word_q;
        addr_d     = addr_q;
        src_d      = src_q;
        old_d      = old_q;
        cnt_d      = cnt_q;
        err_d      = err_q;
        misaligned = i_riscv_amo_word ? (i_riscv_amo_addr[1:0] != 2'b00)
                                      : (i_riscv_amo_addr[2:0] != 3'b000);
        rd_half    = addr_q[2] ? i_riscv_mem_rdata[63:32] : i_riscv_mem_rdata[31:0];
        case (state_q)
            S_IDLE: begin
                cnt_d = '0;
                // Flush wins over a simultaneous request: nothing is latched.
                if (i_riscv_amo_req_valid && !i_riscv_amo_flush) begin
                    funct5_d = i_riscv_amo_funct5;
                    word_d   = i_riscv_amo_word;
                    addr_d   = i_riscv_amo_addr[63:2];
                    src_d    = i_riscv_amo_src;
                    err_d    = misaligned;
                    state_d  = misaligned ? S_RESP : S_READ;
                end
            end
            S_READ: begin
                cnt_d   = '0;
                state_d = i_riscv_amo_flush ? S_IDLE : S_WAIT;
            end
            S_WAIT: begin
                if (i_riscv_amo_flush) begin
                    state_d = S_IDLE;
                end else if (cnt_q == CNT_LAST) begin
                    old_d   = word_q ? {{32{rd_half[31]}}, rd_half} : i_riscv_mem_rdata;
                    state_d = S_WRITE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_WRITE: state_d = S_RESP;
            S_RESP:  if (i_riscv_amo_rsp_ready) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // ALU: .W operands are sign-extended to 64 bits, which keeps both signed
    // and unsigned ordering of the 32-bit values intact.
    always_comb begin
        src_ext = word_q ? {{32{src_q[31]}}, src_q[31:0]} : src_q;
        case (funct5_q)
            F_ADD:   result = old_q + src_ext;
            F_XOR:   result = old_q ^ src_ext;
            F_AND:   result = old_q & src_ext;
            F_OR:    result = old_q | src_ext;
            F_MIN:   result = ($signed(old_q) < $signed(src_ext)) ? old_q : src_ext;
            F_MAX:   result = ($signed(old_q) > $signed(src_ext)) ? old_q : src_ext;
            F_MINU:  result = (old_q < src_ext) ? old_q : src_ext;
            F_MAXU:  result = (old_q > src_ext) ? old_q : src_ext;
            F_SWAP:  result = src_ext;
            default: result = src_ext;
        endcase
    end

    // Outputs decoded from state; buses held at zero outside their active phase.
    always_comb begin
        o_riscv_amo_req_ready = (state_q == S_IDLE);
        o_riscv_mem_en        = (state_q == S_READ) || (state_q == S_WRITE);
        o_riscv_mem_we        = (state_q == S_WRITE);
        o_riscv_mem_addr      = o_riscv_mem_en ? {addr_q[63:3], 3'b000} : 64'd0;
        o_riscv_mem_wdata     = 64'd0;
        o_riscv_mem_wstrb     = 8'h00;
        if (state_q == S_WRITE) begin
            o_riscv_mem_wdata = word_q ? {result[31:0], result[31:0]} : result;
            o_riscv_mem_wstrb = word_q ? (addr_q[2] ? 8'hF0 : 8'h0F) : 8'hFF;
        end
        o_riscv_amo_rsp_valid = (state_q == S_RESP);
        o_riscv_amo_rsp_err   = (state_q == S_RESP) && err_q;
        o_riscv_amo_rsp_data  = ((state_q == S_RESP) && !err_q) ? old_q : 64'd0;
    end

endmodule

// File: tb/tb_riscv_amo_mem_responder.sv
// tb/tb_riscv_amo_mem_responder.sv - directed-vector bench for riscv_amo_mem_responder
module tb_riscv_amo_mem_responder;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [4:0]  funct5 = '0;
    logic        word = 1'b0;
    logic [63:0] addr = '0;
    logic [63:0] src = '0;
    logic        flush = 1'b0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b1;
    logic [63:0] rsp_data;
    logic        rsp_err;
    logic        mem_en, mem_we;
    logic [63:0] mem_addr, wdata;
    logic [7:0]  wstrb;
    logic [63:0] rdata = '0;

    logic [63:0] mem [0:63];
    logic        pl_en = 1'b0;
    logic [5:0]  pl_idx = '0;
    logic [63:0] pl_data = '0;

    int n_tests = 0;
    int n_fail  = 0;

    int          t_rd, t_wr, t_rsp, n_wr, n_en;
    logic [63:0] t_wd, t_rdata;
    logic [7:0]  t_ws;
    logic        t_err;

    always #5 clk = ~clk;

    riscv_amo_mem_responder #(.MEM_RD_LATENCY(1)) dut (
        .i_riscv_lsu_clk       (clk),
        .i_riscv_lsu_rst       (rst),
        .i_riscv_amo_req_valid (req_valid),
        .o_riscv_amo_req_ready (req_ready),
        .i_riscv_amo_funct5    (funct5),
        .i_riscv_amo_word      (word),
        .i_riscv_amo_addr      (addr),
        .i_riscv_amo_src       (src),
        .i_riscv_amo_flush     (flush),
        .o_riscv_amo_rsp_valid (rsp_valid),
        .i_riscv_amo_rsp_ready (rsp_ready),
        .o_riscv_amo_rsp_data  (rsp_data),
        .o_riscv_amo_rsp_err   (rsp_err),
        .o_riscv_mem_en        (mem_en),
        .o_riscv_mem_we        (mem_we),
        .o_riscv_mem_addr      (mem_addr),
        .o_riscv_mem_wdata     (wdata),
        .o_riscv_mem_wstrb     (wstrb),
        .i_riscv_mem_rdata     (rdata)
    );

    // Single-port memory with one-cycle read latency and byte strobes.
    always @(posedge clk) begin
        if (pl_en) begin
            mem[pl_idx] <= pl_data;
        end else if (mem_en && !mem_we) begin
            rdata <= mem[mem_addr[8:3]];
        end else if (mem_en && mem_we) begin
            for (int b = 0; b < 8; b++)
                if (wstrb[b]) mem[mem_addr[8:3]][b*8 +: 8] <= wdata[b*8 +: 8];
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%016h expected 0x%016h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic preload(input logic [5:0] idx, input logic [63:0] d);
        pl_idx  = idx;
        pl_data = d;
        pl_en   = 1'b1;
        tick();
        pl_en   = 1'b0;
    endtask

    // Issue one request with rsp_ready high; record cycle offsets of each phase.
    task automatic amo(input logic [4:0] f, input logic w, input logic [63:0] a, input logic [63:0] s);
        t_rd = -1; t_wr = -1; t_rsp = -1; n_wr = 0; n_en = 0;
        t_wd = '0; t_ws = '0; t_rdata = '0; t_err = 1'b0;
        req_valid = 1'b1; funct5 = f; word = w; addr = a; src = s;
        for (int c = 0; c < 30; c++) begin
            if (mem_en) begin
                n_en++;
                if (mem_we) begin
                    n_wr++; t_wr = c; t_wd = wdata; t_ws = wstrb;
                end else begin
                    t_rd = c;
                end
            end
            if (rsp_valid) begin
                t_rsp = c; t_rdata = rsp_data; t_err = rsp_err;
            end
            tick();
            req_valid = 1'b0;
            if (t_rsp >= 0) break;
        end
    endtask

    initial begin
        #12;
        check("rst_ready", {63'd0, req_ready}, 64'd1);
        check("rst_rsp_valid", {63'd0, rsp_valid}, 64'd0);
        check("rst_mem_en", {63'd0, mem_en}, 64'd0);
        check("rst_rsp_data", rsp_data, 64'd0);
        check("rst_wstrb", {56'd0, wstrb}, 64'd0);
        @(negedge clk);
        rst = 1'b0;
        tick();

        // AMOADD.D
        preload(6'd32, 64'h5);
        amo(5'b00000, 1'b0, 64'h100, 64'h3);
        check("add_rd_cyc", t_rd, 64'd1);
        check("add_wr_cyc", t_wr, 64'd3);
        check("add_rsp_cyc", t_rsp, 64'd4);
        check("add_wdata", t_wd, 64'h8);
        check("add_wstrb", {56'd0, t_ws}, 64'hFF);
        check("add_rsp_data", t_rdata, 64'h5);
        check("add_nwr", n_wr, 64'd1);
        check("add_mem", mem[32], 64'h8);
        check("add_ready_after", {63'd0, req_ready}, 64'd1);

        // AMOMIN.W / AMOMINU.W on the upper word
        preload(6'd32, 64'hFFFFFFFE_12345678);
        amo(5'b10000, 1'b1, 64'h104, 64'h1);
        check("min_wdata", t_wd, 64'hFFFFFFFE_FFFFFFFE);
        check("min_wstrb", {56'd0, t_ws}, 64'hF0);
        check("min_rsp", t_rdata, 64'hFFFFFFFF_FFFFFFFE);
        check("min_mem", mem[32], 64'hFFFFFFFE_12345678);
        preload(6'd32, 64'hFFFFFFFE_12345678);
        amo(5'b11000, 1'b1, 64'h104, 64'h1);
        check("minu_wdata", t_wd, 64'h00000001_00000001);
        check("minu_rsp", t_rdata, 64'hFFFFFFFF_FFFFFFFE);
        check("minu_mem", mem[32], 64'h00000001_12345678);

        // Lower-word ops, wrap, signed/unsigned max, unknown funct5
        preload(6'd33, 64'hAAAAAAAA_F0F0F0F0);
        amo(5'b00100, 1'b1, 64'h108, 64'h00000000_FF00FF00);
        check("xorw_wdata", t_wd, 64'h0FF00FF0_0FF00FF0);
        check("xorw_wstrb", {56'd0, t_ws}, 64'h0F);
        check("xorw_rsp", t_rdata, 64'hFFFFFFFF_F0F0F0F0);
        check("xorw_mem", mem[33], 64'hAAAAAAAA_0FF00FF0);
        preload(6'd33, 64'h00000000_FFFFFFFF);
        amo(5'b00000, 1'b1, 64'h108, 64'h1);
        check("addw_wrap", t_wd, 64'h0);
        check("addw_rsp", t_rdata, 64'hFFFFFFFF_FFFFFFFF);
        preload(6'd33, 64'hFFFFFFFF_FFFFFFFB);
        amo(5'b10100, 1'b0, 64'h108, 64'h3);
        check("max_wdata", t_wd, 64'h3);
        preload(6'd33, 64'hFFFFFFFF_FFFFFFFB);
        amo(5'b11100, 1'b0, 64'h108, 64'h3);
        check("maxu_wdata", t_wd, 64'hFFFFFFFF_FFFFFFFB);
        preload(6'd33, 64'hFF00FF00_FF00FF00);
        amo(5'b01100, 1'b0, 64'h108, 64'h0F0F0F0F_0F0F0F0F);
        check("and_wdata", t_wd, 64'h0F000F00_0F000F00);
        amo(5'b01000, 1'b0, 64'h108, 64'h00000000_000000F0);
        check("or_wdata", t_wd, 64'h0F000F00_0F000FF0);
        amo(5'b11111, 1'b0, 64'h108, 64'h12345678_9ABCDEF0);
        check("unk_swap", t_wd, 64'h12345678_9ABCDEF0);

        // Misaligned AMOSWAP.D
        amo(5'b00001, 1'b0, 64'h103, 64'h77);
        check("mis_en", n_en, 64'd0);
        check("mis_err", {63'd0, t_err}, 64'd1);
        check("mis_data", t_rdata, 64'd0);
        check("mis_rsp_cyc", t_rsp, 64'd1);

        // Flush in WAIT
        preload(6'd33, 64'h0F);
        req_valid = 1'b1; funct5 = 5'b01000; word = 1'b0; addr = 64'h108; src = 64'hF0;
        tick();
        req_valid = 1'b0;
        check("fl_read_en", {63'd0, mem_en}, 64'd1);
        tick();
        flush = 1'b1;
        check("fl_wait_en", {63'd0, mem_en}, 64'd0);
        tick();
        flush = 1'b0;
        check("fl_ready", {63'd0, req_ready}, 64'd1);
        n_en = 0;
        for (int c = 0; c < 4; c++) begin
            if (mem_en || rsp_valid) n_en++;
            tick();
        end
        check("fl_quiet", n_en, 64'd0);
        check("fl_mem", mem[33], 64'h0F);

        // Flush with request in IDLE
        req_valid = 1'b1; flush = 1'b1;
        tick();
        check("flv_ready", {63'd0, req_ready}, 64'd1);
        check("flv_en", {63'd0, mem_en}, 64'd0);
        req_valid = 1'b0; flush = 1'b0;
        tick();
        check("flv_en2", {63'd0, mem_en}, 64'd0);

        // Response backpressure
        preload(6'd34, 64'h1234);
        rsp_ready = 1'b0;
        req_valid = 1'b1; funct5 = 5'b00001; word = 1'b0; addr = 64'h110; src = 64'hAA;
        for (int c = 0; c < 10; c++) begin
            tick();
            req_valid = 1'b0;
            if (rsp_valid) break;
        end
        check("bp_valid0", {63'd0, rsp_valid}, 64'd1);
        for (int c = 0; c < 5; c++) begin
            check("bp_valid", {63'd0, rsp_valid}, 64'd1);
            check("bp_data", rsp_data, 64'h1234);
            check("bp_ready", {63'd0, req_ready}, 64'd0);
            tick();
        end
        rsp_ready = 1'b1;
        tick();
        check("bp_ready_after", {63'd0, req_ready}, 64'd1);
        check("bp_mem", mem[34], 64'hAA);

        // Reset in WAIT
        preload(6'd35, 64'd10);
        req_valid = 1'b1; funct5 = 5'b00000; word = 1'b0; addr = 64'h118; src = 64'h1;
        tick();
        req_valid = 1'b0;
        tick();
        #1 rst = 1'b1;
        #1;
        check("ar_ready", {63'd0, req_ready}, 64'd1);
        check("ar_en", {63'd0, mem_en}, 64'd0);
        check("ar_rsp_valid", {63'd0, rsp_valid}, 64'd0);
        check("ar_mem_addr", mem_addr, 64'd0);
        @(negedge clk);
        rst = 1'b0;
        tick();
        check("ar_mem", mem[35], 64'd10);
        amo(5'b00000, 1'b0, 64'h118, 64'h1);
        check("ar2_rsp", t_rdata, 64'd10);
        check("ar2_wdata", t_wd, 64'd11);
        check("ar2_rsp_cyc", t_rsp, 64'd4);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
